// File: rtl/sifre_cozme.sv
// Receive side of the serial encryption link: collects an LSB-first frame of
// BIT bits, then reverses the 2-bit rotation and the key mix chosen at frame start.
module sifre_cozme #(
    parameter int BIT = 4
) (
    input  logic           saat,
    input  logic           reset,
    input  logic           bit_girisi,
    input  logic           gecerli_girisi,
    input  logic           mod,
    input  logic [2:0]     secim,
    output logic [BIT-1:0] veri,
    output logic           cikis_gecerli,
    output logic           hata
);

    typedef enum logic {BOSTA = 1'b0, ALIM = 1'b1} durum_t;

    localparam logic [5:0] SON = 6'(BIT - 1);

    durum_t         durum_q, durum_d;
    logic [5:0]     sayac_q, sayac_d;
    logic [BIT-1:0] kaydirma_q, kaydirma_d;
    logic           mod_q, mod_d;
    logic [2:0]     secim_q, secim_d;
    logic [BIT-1:0] veri_q, veri_d;
    logic           gecerli_q, gecerli_d;
    logic           hata_q, hata_d;
    logic [BIT-1:0] tek_bit_s;
    logic [BIT-1:0] cerceve_s;

    function automatic logic [63:0] anahtar(input logic [2:0] idx);
        case (idx)
            3'd0:    return 64'hBABA_1453_DEDE_1071;
            3'd1:    return 64'hACAB_0909_BACA_0707;
            3'd2:    return 64'hADAB_0606_DADA_0505;
            3'd3:    return 64'hAAAA_0000_FFFF_5555;
            3'd4:    return 64'hCAAA_0101_CAAA_0101;
            3'd5:    return 64'hAACA_0606_AACA_0606;
            3'd6:    return 64'hCAAA_1717_CAAA_1717;
            3'd7:    return 64'hAAAA_0000_FFFF_5555;
            default: return 64'h0000_0000_0000_0000;
        endcase
    endfunction

    // The transmitter rotated left for mod=1 and right for mod=0; undo that here.
    function automatic logic [BIT-1:0] coz(input logic [BIT-1:0] s, input logic m,
                                           input logic [2:0] sec);
        logic [BIT-1:0] k;
        logic [BIT-1:0] t;
        k = BIT'(anahtar(sec));
        if (m) begin
            t = {s[1:0], s[BIT-1:2]};
            return t ^ k;
        end else begin
            t = {s[BIT-3:0], s[BIT-1:BIT-2]};
            return ~(t ^ k);
        end
    endfunction

    assign tek_bit_s = {{(BIT-1){1'b0}}, bit_girisi};
    // Unfilled positions are always zero, so OR-ing the new bit in place is enough.
    assign cerceve_s = kaydirma_q | (tek_bit_s << sayac_q);

    // Next-state and next-output logic for the receive FSM.
    always_comb begin
        durum_d    = durum_q;
        sayac_d    = sayac_q;
        kaydirma_d = kaydirma_q;
        mod_d      = mod_q;
        secim_d    = secim_q;
        veri_d     = veri_q;
        gecerli_d  = 1'b0;
        hata_d     = 1'b0;
        case (durum_q)
            BOSTA: begin
                if (gecerli_girisi) begin
                    kaydirma_d = tek_bit_s;
                    mod_d      = mod;
                    secim_d    = secim;
                    sayac_d    = 6'd1;
                    durum_d    = ALIM;
                end else begin
                    durum_d = BOSTA;
                end
            end
            ALIM: begin
                if (gecerli_girisi) begin
                    if (sayac_q == SON) begin
                        veri_d     = coz(cerceve_s, mod_q, secim_q);
                        gecerli_d  = 1'b1;
                        kaydirma_d = '0;
                        sayac_d    = 6'd0;
                        durum_d    = BOSTA;
                    end else begin
                        kaydirma_d = cerceve_s;
                        sayac_d    = sayac_q + 6'd1;
                    end
                end else begin
                    hata_d     = 1'b1;
                    kaydirma_d = '0;
                    sayac_d    = 6'd0;
                    durum_d    = BOSTA;
                end
            end
            default: begin
                kaydirma_d = '0;
                sayac_d    = 6'd0;
                durum_d    = BOSTA;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge saat) begin
        if (reset) begin
            durum_q    <= BOSTA;
            sayac_q    <= 6'd0;
            kaydirma_q <= '0;
            mod_q      <= 1'b0;
            secim_q    <= 3'd0;
            veri_q     <= '0;
            gecerli_q  <= 1'b0;
            hata_q     <= 1'b0;
        end else begin
            durum_q    <= durum_d;
            sayac_q    <= sayac_d;
            kaydirma_q <= kaydirma_d;
            mod_q      <= mod_d;
            secim_q    <= secim_d;
            veri_q     <= veri_d;
            gecerli_q  <= gecerli_d;
            hata_q     <= hata_d;
        end
    end

    assign veri          = veri_q;
    assign cikis_gecerli = gecerli_q;
    assign hata          = hata_q;

endmodule

// File: doc/sifre_cozme.md
Name: sifre_cozme

Overview:
- Receive end of the serial encryption link.
- Accepts the LSB-first bit stream and its per-bit valid from the encrypting transmitter.
- Deserialises one BIT-wide frame and undoes the rotation and key mix, presenting the recovered plaintext word with a one-cycle valid pulse.
- Sits directly on the transmitter's bit/valid outputs; key table and mode semantics are identical to the transmitter's.

Parameters:
- BIT, 4, frame/word width in bits. Legal range 3..64. Must match the transmitter.

Ports:
- saat  input  1  clock, all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- bit_girisi  input  1  serial data bit, LSB of frame first
- gecerli_girisi  input  1  bit_girisi valid this cycle
- mod  input  1  1: XOR / rotate-left-2 frame; 0: XNOR / rotate-right-2 frame
- secim  input  3  key index 0..7
- veri  output  BIT  decrypted word, registered
- cikis_gecerli  output  1  one-cycle pulse, veri valid
- hata  output  1  one-cycle pulse, frame aborted

Behaviour:
- Key table, 64-bit entries, only bits [BIT-1:0] used:
  - 0: BABA_1453_DEDE_1071
  - 1: ACAB_0909_BACA_0707
  - 2: ADAB_0606_DADA_0505
  - 3: AAAA_0000_FFFF_5555
  - 4: CAAA_0101_CAAA_0101
  - 5: AACA_0606_AACA_0606
  - 6: CAAA_1717_CAAA_1717
  - 7: AAAA_0000_FFFF_5555
- Reset (edge with reset=1):
  - veri=0, cikis_gecerli=0, hata=0.
  - Shift register=0, sayac=0, state=BOSTA.
  - Overrides any frame in progress; partial frame discarded, no hata.
- States: BOSTA, ALIM. Counter sayac is 6 bits.
- BOSTA:
  - If gecerli_girisi=1: store bit_girisi at frame bit 0, latch mod and secim, sayac<=1, go ALIM.
  - Otherwise hold.
  - mod/secim are sampled only at this first bit; later changes are ignored for the frame.
- ALIM:
  - If gecerli_girisi=1: store bit_girisi at frame bit index sayac, sayac<=sayac+1.
  - When sayac==BIT-1 this is the last bit. On the same edge:
    - compute s = received frame including this bit;
    - load veri = decrypt(s);
    - set cikis_gecerli<=1;
    - go BOSTA.
  - If gecerli_girisi=0 mid-frame: hata<=1 for one cycle, discard frame, go BOSTA, veri unchanged.
- Decrypt, using the latched mod and key k = key[secim][BIT-1:0]:
  - mod=1: t = {s[1:0], s[BIT-1:2]} (rotate right 2); veri = t ^ k.
  - mod=0: t = {s[BIT-3:0], s[BIT-1:BIT-2]} (rotate left 2); veri = ~(t ^ k).
- Latency: cikis_gecerli is high in the cycle immediately following the cycle in which the last valid bit was presented.
- Back-to-back frames: cikis_gecerli and hata never exceed one cycle.
  - BOSTA accepts a new first bit in any cycle, including the cycle cikis_gecerli is high.
  - The transmitter's idle gap is not required.
- veri holds its last decrypted value until the next completed frame.
- Outputs are driven only from registers; no combinational path from inputs.

Test Plan:
- BIT=4, mod=1, secim=0, serial bits 0,1,1,1 (frame 0xE) with continuous valid -> veri=0xA, cikis_gecerli high exactly one cycle, one cycle after the 4th bit.
- BIT=4, mod=0, secim=3, bits 0,1,1,0 (0x6) -> veri=0x3. Toggle mod/secim after the first bit -> result unchanged.
- BIT=8, mod=1, secim=4, frame 0x75 LSB-first -> veri=0x5C.
- BIT=4, valid drops after 2 bits -> hata pulses one cycle, no cikis_gecerli, veri keeps its previous value. The next full frame decodes correctly.
- Reset asserted after bit 2 of a frame -> all outputs 0, no pulse. The following frame 0xE (mod=1, secim=0) -> veri=0xA.
- Two frames with no idle cycle between them (0xE then 0x6 with mod=0, secim=3) -> veri=0xA then 0x3, on pulses 4 cycles apart. End-to-end loop with the transmitter for all 8 keys, both modes, 256 random words at BIT=8 -> veri equals the transmitter input.
